multicore_data_memory: RTL and testbench
========================================

Name: multicore_data_memory

Overview:
- Shared single-bank data memory serving NUM_CORES core ports through a round-robin arbiter.
- Each core issues read or write requests with a req/grant handshake.
- One access is accepted per cycle. Read data is returned one cycle after acceptance with a per-core valid strobe.
- Sits between the core array and the shared data store. It is the parametrised, multi-requester successor of the single-port data RAM.

Parameters:
- MEM_INIT, 0, 1 = preload memory from the data-mem init file at elaboration (simulation only).
- WIDTH, 12, data word width in bits.
- DEPTH, 1024, number of words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- NUM_CORES, 4, number of requester ports (≥1).
- CORE_ID_WIDTH, max(1,$clog2(NUM_CORES)), width of granted-core index.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_CORES  per-core request valid.
- writeEn  input  NUM_CORES  per-core access type: 1 = write, 0 = read; qualified by req.
- address  input  NUM_CORES*ADDR_WIDTH  per-core address, core i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- dataIn  input  NUM_CORES*WIDTH  per-core write data, core i at [i*WIDTH +: WIDTH].
- grant  output  NUM_CORES  one-hot combinational grant; the request is accepted at the edge where req[i]&grant[i].
- dataOut  output  NUM_CORES*WIDTH  per-core registered read data.
- readValid  output  NUM_CORES  one-cycle strobe: dataOut slice for that core is fresh.
- busyCore  output  CORE_ID_WIDTH  index of the core granted this cycle; 0 when no grant.
- processDone  input  1  simulation only: on rising level, dump memory to the data-mem output file.

Behaviour:
- Reset (sync, reset=1 at an edge):
  - rrPtr cleared to 0.
  - readValid = 0; all dataOut slices = 0.
  - grant is forced to 0 while reset=1.
  - Memory contents are not cleared.
  - A read accepted in the cycle before reset produces no readValid.
- Arbitration (combinational from req and rrPtr):
  - Search cores rrPtr, rrPtr+1, …, wrapping modulo NUM_CORES.
  - The first core with req=1 gets grant. At most one grant bit is high.
  - grant = 0 when req = 0.
  - A grant does not depend on the requester dropping req later in the cycle.
- Pointer update: on an accepted access by core k, rrPtr ← (k+1) mod NUM_CORES. Unchanged when there is no grant.
- Fairness: with all cores continuously requesting, grants rotate 0,1,2,3,0,…; each core waits at most NUM_CORES-1 cycles.
- Write (accepted, writeEn[k]=1): memory[address_k] ← dataIn_k at that edge; readValid[k] is not asserted.
- Read (accepted, writeEn[k]=0):
  - At edge T, dataOut_k ← memory[address_k] (pre-write contents; only one access per edge, so no same-edge conflict).
  - readValid[k]=1 during cycle T+1 only.
  - Read latency: 1 cycle from accepting edge to data visible.
- dataOut_k holds its value until core k's next accepted read. Other cores' accesses do not disturb it.
- Back-to-back:
  - A write by core A at edge T followed by a read of the same address by any core at T+1 returns the new data.
  - One core may be granted on consecutive cycles only if no other core requests (pointer rotation).
- Non-granted requesters must hold req, writeEn, address and dataIn stable until granted. The block does not latch un-granted requests.
- Address is used as-is; DEPTH equal to a power of two means there is no out-of-range case. If DEPTH is not a power of two, out-of-range addresses are ignored for writes and return 0 for reads (readValid still pulses).
- NUM_CORES=1: the arbiter degenerates to grant=req and busyCore=0.

Test Plan:
- Reset then idle: after reset held 2 cycles → grant=0000, readValid=0000, all dataOut=0, busyCore=0.
- Single write/read: core2 writes 12'hA5C to addr 10'h03F; the next cycle core2 reads 10'h03F → grant[2] each cycle; one cycle after the read accept, readValid=0100 and dataOut core2 slice=12'hA5C.
- Round-robin fairness: all 4 cores request reads continuously from rrPtr=0 → grants 0,1,2,3,0,1 on consecutive cycles; each readValid[i] pulses exactly one cycle after its grant.
- Cross-core RAW: core0 writes 12'h123 to addr 5; in the next cycle only core3 reads addr 5 → core3 dataOut=12'h123 with readValid[3] next cycle.
- Pointer skip/wrap: rrPtr=3 with req=0101 → grant=0001 (core0), then rrPtr=1 → next grant core2; drop req → grant=0, rrPtr holds 3.
- Reset mid-operation: core1 read accepted, then reset asserted on the following edge → readValid[1] stays 0 and dataOut=0; memory word written before reset still reads back correctly after reset.

Source files
------------

// File: rtl/multicore_data_memory.sv
// Shared single-bank data memory for NUM_CORES requesters.
// Round-robin arbitration, one access per cycle, 1-cycle read latency.
module multicore_data_memory #(
  parameter int MEM_INIT      = 0,
  parameter int WIDTH         = 12,
  parameter int DEPTH         = 1024,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int NUM_CORES     = 4,
  parameter int CORE_ID_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES-1:0]            writeEn,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] address,
  input  logic [NUM_CORES*WIDTH-1:0]      dataIn,
  output logic [NUM_CORES-1:0]            grant,
  output logic [NUM_CORES*WIDTH-1:0]      dataOut,
  output logic [NUM_CORES-1:0]            readValid,
  output logic [CORE_ID_WIDTH-1:0]        busyCore,
  input  logic                            processDone
);

  localparam bit FULL = (DEPTH == (1 << ADDR_WIDTH));

  logic [WIDTH-1:0]           mem [DEPTH];
  logic [CORE_ID_WIDTH-1:0]   rr_ptr;
  logic [CORE_ID_WIDTH-1:0]   sel;
  logic [CORE_ID_WIDTH-1:0]   rr_next;
  logic                       hit;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [WIDTH-1:0]           sel_data;
  logic                       in_range;
  logic                       accept_wr;
  logic                       accept_rd;
  logic [NUM_CORES-1:0]       valid_q;
  logic [NUM_CORES*WIDTH-1:0] data_q;
  logic                       unused_ok;

  // First requester at or after rr_ptr, wrapping
  always_comb begin
    int c;
    c   = 0;
    sel = '0;
    hit = 1'b0;
    for (int j = 0; j < NUM_CORES; j++) begin
      c = (int'(rr_ptr) + j) % NUM_CORES;
      if (!hit && req[c]) begin
        hit = 1'b1;
        sel = CORE_ID_WIDTH'(c);
      end
    end
    if (reset) hit = 1'b0;
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CORES; i++)
      grant[i] = hit && (int'(sel) == i);
  end

  assign busyCore  = hit ? sel : '0;
  assign rr_next   = CORE_ID_WIDTH'((int'(sel) + 1) % NUM_CORES);
  assign sel_addr  = address[sel*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = dataIn[sel*WIDTH +: WIDTH];
  assign in_range  = FULL || (32'(sel_addr) < DEPTH);
  assign accept_wr = hit && writeEn[sel];
  assign accept_rd = hit && !writeEn[sel];

  // Storage is never reset
  always_ff @(posedge clock) begin
    if (accept_wr && in_range)
      mem[sel_addr] <= sel_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr  <= '0;
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= '0;
      if (hit) rr_ptr <= rr_next;
      if (accept_rd) begin
        valid_q <= grant;
        data_q[sel*WIDTH +: WIDTH] <= in_range ? mem[sel_addr] : '0;
      end
    end
  end

  // A read accepted just before reset must not strobe
  assign readValid = valid_q & {NUM_CORES{~reset}};
  assign dataOut   = data_q;

  assign unused_ok = &{1'b0, processDone, (MEM_INIT != 0)};

endmodule

// File: tb/tb_multicore_data_memory.sv
// Bench for multicore_data_memory: reference arbiter/memory model
// with a scoreboard queue of expected read returns.
module tb_multicore_data_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  writeEn;
  logic [39:0] address;
  logic [47:0] dataIn;
  logic [3:0]  grant;
  logic [47:0] dataOut;
  logic [3:0]  readValid;
  logic [1:0]  busyCore;
  logic        processDone;

  typedef struct {
    int         core;
    logic [11:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] m_mem [1024];
  int          m_rr;
  logic [3:0]  exp_valid;
  logic [3:0]  obs_grant;
  logic [3:0]  obs_valid;
  int          checks;
  int          errors;

  multicore_data_memory dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .writeEn    (writeEn),
    .address    (address),
    .dataIn     (dataIn),
    .grant      (grant),
    .dataOut    (dataOut),
    .readValid  (readValid),
    .busyCore   (busyCore),
    .processDone(processDone)
  );

  always #5 clock = ~clock;

  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [9:0] a, input logic [11:0] d);
    req[c]            = r;
    writeEn[c]        = w;
    address[c*10 +: 10] = a;
    dataIn[c*12 +: 12]  = d;
  endtask

  // One cycle: check outputs mid-cycle, then advance the model at the edge
  task automatic tick();
    logic [3:0] eg;
    logic [3:0] ev;
    int         k;
    bit         any;
    exp_t       e;
    @(negedge clock);
    obs_grant = grant;
    obs_valid = readValid;
    ev = reset ? 4'b0 : exp_valid;
    checks++;
    if (readValid !== ev) begin
      errors++;
      $display("FAIL readValid got %b want %b", readValid, ev);
    end
    if (reset) sb.delete();
    else if (exp_valid != 4'b0 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (dataOut[e.core*12 +: 12] !== e.data) begin
        errors++;
        $display("FAIL read_data core%0d got %h want %h",
                 e.core, dataOut[e.core*12 +: 12], e.data);
      end
    end
    eg  = 4'b0;
    any = 1'b0;
    k   = 0;
    if (!reset) begin
      for (int j = 0; j < 4; j++) begin
        int c;
        c = (m_rr + j) % 4;
        if (!any && req[c]) begin
          any   = 1'b1;
          k     = c;
          eg[c] = 1'b1;
        end
      end
    end
    checks++;
    if (grant !== eg || busyCore !== 2'(k)) begin
      errors++;
      $display("FAIL arb grant %b busy %0d want %b busy %0d",
               grant, busyCore, eg, k);
    end
    @(posedge clock);
    exp_valid = 4'b0;
    if (reset) begin
      m_rr = 0;
    end else if (any) begin
      m_rr = (k + 1) % 4;
      if (writeEn[k]) m_mem[address[k*10 +: 10]] = dataIn[k*12 +: 12];
      else begin
        exp_valid[k] = 1'b1;
        sb.push_back('{k, m_mem[address[k*10 +: 10]]});
      end
    end
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dataOut !== 48'h0 || busyCore !== 2'd0 || readValid !== 4'b0) begin
      errors++;
      $display("FAIL reset_state dout %h busy %0d rv %b",
               dataOut, busyCore, readValid);
    end
    tick();
    checks++;
    if (obs_grant !== 4'b0) begin
      errors++;
      $display("FAIL reset_idle_grant got %b want 0000", obs_grant);
    end
  endtask

  task automatic test_single();
    set_core(2, 1'b1, 1'b1, 10'h03F, 12'hA5C);
    tick();
    checks++;
    if (obs_grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_wr_grant got %b want 0100", obs_grant);
    end
    set_core(2, 1'b1, 1'b0, 10'h03F, 12'h000);
    tick();
    checks++;
    if (obs_grant !== 4'b0100) begin
      errors++;
      $display("FAIL single_rd_grant got %b want 0100", obs_grant);
    end
    req = 4'b0;
    tick();
    checks++;
    if (obs_valid !== 4'b0100 || dataOut[24 +: 12] !== 12'hA5C) begin
      errors++;
      $display("FAIL single_rd_data rv %b d %h want 0100 a5c",
               obs_valid, dataOut[24 +: 12]);
    end
  endtask

  task automatic test_raw();
    set_core(0, 1'b1, 1'b1, 10'd5, 12'h123);
    tick();
    req = 4'b0;
    set_core(3, 1'b1, 1'b0, 10'd5, 12'h000);
    tick();
    checks++;
    if (obs_grant !== 4'b1000) begin
      errors++;
      $display("FAIL raw_grant got %b want 1000", obs_grant);
    end
    req = 4'b0;
    tick();
    checks++;
    if (obs_valid !== 4'b1000 || dataOut[36 +: 12] !== 12'h123) begin
      errors++;
      $display("FAIL raw_data rv %b d %h want 1000 123",
               obs_valid, dataOut[36 +: 12]);
    end
    checks++;
    if (dataOut[24 +: 12] !== 12'hA5C) begin
      errors++;
      $display("FAIL hold_core2 got %h want a5c", dataOut[24 +: 12]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    set_core(0, 1'b1, 1'b0, 10'h03F, 12'h0);
    set_core(1, 1'b1, 1'b0, 10'd5,   12'h0);
    set_core(2, 1'b1, 1'b0, 10'h03F, 12'h0);
    set_core(3, 1'b1, 1'b0, 10'd5,   12'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      want = 4'b0001 << (i % 4);
      checks++;
      if (obs_grant !== want) begin
        errors++;
        $display("FAIL rr_seq step %0d got %b want %b", i, obs_grant, want);
      end
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_skip_wrap();
    set_core(2, 1'b1, 1'b0, 10'h03F, 12'h0);
    tick();
    set_core(0, 1'b1, 1'b0, 10'd5, 12'h0);
    tick();
    checks++;
    if (obs_grant !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_grant got %b want 0001", obs_grant);
    end
    tick();
    checks++;
    if (obs_grant !== 4'b0100) begin
      errors++;
      $display("FAIL skip_grant got %b want 0100", obs_grant);
    end
    req = 4'b0;
    tick();
    req = 4'b1111;
    tick();
    checks++;
    if (obs_grant !== 4'b1000) begin
      errors++;
      $display("FAIL ptr_hold got %b want 1000", obs_grant);
    end
    req = 4'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_core(1, 1'b1, 1'b1, 10'd7, 12'h777);
    tick();
    set_core(1, 1'b1, 1'b0, 10'd7, 12'h000);
    tick();
    req   = 4'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 4'b0) begin
      errors++;
      $display("FAIL reset_mid_valid got %b want 0000", obs_valid);
    end
    reset = 1'b0;
    checks++;
    if (dataOut[12 +: 12] !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_data got %h want 000", dataOut[12 +: 12]);
    end
    tick();
    set_core(1, 1'b1, 1'b0, 10'd7, 12'h000);
    tick();
    req = 4'b0;
    tick();
    checks++;
    if (obs_valid !== 4'b0010 || dataOut[12 +: 12] !== 12'h777) begin
      errors++;
      $display("FAIL mem_kept rv %b d %h want 0010 777",
               obs_valid, dataOut[12 +: 12]);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    m_rr        = 0;
    exp_valid   = 4'b0;
    reset       = 1'b1;
    req         = 4'b0;
    writeEn     = 4'b0;
    address     = 40'h0;
    dataIn      = 48'h0;
    processDone = 1'b0;
    test_reset();
    test_single();
    test_raw();
    test_round_robin();
    test_skip_wrap();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
